// File: rtl/crc_frame_rx_ctrl.sv
// Receive-side frame controller for LEN/PAYLOAD/CRC_LO/CRC_HI frames around a shared CRC-16/MODBUS engine.
// Optional macro FRAME_TIMEOUT_EN adds an inter-byte timeout that aborts a frame with error code 3.
module crc_frame_rx_ctrl #(
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [15:0] crc_in,
    output logic        crc_en,
    output logic        crc_clr,
    output logic [7:0]  crc_data,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    output logic        pay_last,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [1:0]  frame_err,
    output logic        rx_drop,
    output logic        busy
);
    localparam logic [7:0] MAX_LEN_C = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_CRC_LO = 3'd2,
        ST_CRC_HI = 3'd3,
        ST_CHECK  = 3'd4,
        ST_CLEAR  = 3'd5
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] rem_r, rem_s;
    logic [7:0] crc_lo_r, crc_lo_s;
    logic [7:0] crc_hi_r, crc_hi_s;
    logic [7:0] data_r, data_s;
    logic       stb_r, stb_s;
    logic       last_r, last_s;
    logic       clr_r, clr_s;
    logic       done_r, done_s;
    logic       ok_r, ok_s;
    logic [1:0] err_r, err_s;
    logic       drop_r, drop_s;
    logic       busy_r, busy_s;
    logic       to_hit_s;

`ifdef FRAME_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST_C = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_r, to_cnt_s;
    logic            timed_s;

    assign timed_s = (state_r == ST_DATA) || (state_r == ST_CRC_LO) || (state_r == ST_CRC_HI);

    // Inter-byte silence counter; any accepted byte or a non-waiting state clears it
    always_comb begin
        to_cnt_s = TO_W'(0);
        to_hit_s = 1'b0;
        if (timed_s && !rx_valid) begin
            if (to_cnt_r == TO_LAST_C) begin
                to_hit_s = 1'b1;
            end else begin
                to_cnt_s = to_cnt_r + TO_W'(1);
            end
        end else begin
            to_cnt_s = TO_W'(0);
        end
    end

    // Silence counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_r <= TO_W'(0);
        end else begin
            to_cnt_r <= to_cnt_s;
        end
    end
`else
    logic [TO_W-1:0] to_unused_s;
    assign to_unused_s = TO_W'(TIMEOUT);
    assign to_hit_s    = 1'b0;
`endif

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_s  = state_r;
        rem_s    = rem_r;
        crc_lo_s = crc_lo_r;
        crc_hi_s = crc_hi_r;
        data_s   = data_r;
        stb_s    = 1'b0;
        last_s   = 1'b0;
        clr_s    = 1'b0;
        done_s   = 1'b0;
        ok_s     = 1'b0;
        err_s    = 2'd0;
        drop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rx_valid) begin
                    state_s = ST_IDLE;
                end else if (rx_data > MAX_LEN_C) begin
                    done_s  = 1'b1;
                    err_s   = 2'd2;
                    state_s = ST_CLEAR;
                end else if (rx_data == 8'd0) begin
                    state_s = ST_CRC_LO;
                end else begin
                    rem_s   = rx_data;
                    state_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    stb_s  = 1'b1;
                    data_s = rx_data;
                    rem_s  = rem_r - 8'd1;
                    if (rem_r == 8'd1) begin
                        last_s  = 1'b1;
                        state_s = ST_CRC_LO;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else if (to_hit_s) begin
                    done_s  = 1'b1;
                    err_s   = 2'd3;
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CRC_LO: begin
                if (rx_valid) begin
                    crc_lo_s = rx_data;
                    state_s  = ST_CRC_HI;
                end else if (to_hit_s) begin
                    done_s  = 1'b1;
                    err_s   = 2'd3;
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_CRC_LO;
                end
            end
            ST_CRC_HI: begin
                if (rx_valid) begin
                    crc_hi_s = rx_data;
                    state_s  = ST_CHECK;
                end else if (to_hit_s) begin
                    done_s  = 1'b1;
                    err_s   = 2'd3;
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_CRC_HI;
                end
            end
            ST_CHECK: begin
                done_s = 1'b1;
                drop_s = rx_valid;
                if ({crc_hi_r, crc_lo_r} == crc_in) begin
                    ok_s  = 1'b1;
                    err_s = 2'd0;
                end else begin
                    ok_s  = 1'b0;
                    err_s = 2'd1;
                end
                state_s = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_s   = 1'b1;
                drop_s  = rx_valid;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, frame latches and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            rem_r    <= 8'd0;
            crc_lo_r <= 8'd0;
            crc_hi_r <= 8'd0;
            data_r   <= 8'd0;
            stb_r    <= 1'b0;
            last_r   <= 1'b0;
            clr_r    <= 1'b0;
            done_r   <= 1'b0;
            ok_r     <= 1'b0;
            err_r    <= 2'd0;
            drop_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            rem_r    <= rem_s;
            crc_lo_r <= crc_lo_s;
            crc_hi_r <= crc_hi_s;
            data_r   <= data_s;
            stb_r    <= stb_s;
            last_r   <= last_s;
            clr_r    <= clr_s;
            done_r   <= done_s;
            ok_r     <= ok_s;
            err_r    <= err_s;
            drop_r   <= drop_s;
            busy_r   <= busy_s;
        end
    end

    assign crc_en     = stb_r;
    assign pay_valid  = stb_r;
    assign crc_data   = data_r;
    assign pay_data   = data_r;
    assign pay_last   = last_r;
    assign crc_clr    = clr_r;
    assign frame_done = done_r;
    assign frame_ok   = ok_r;
    assign frame_err  = err_r;
    assign rx_drop    = drop_r;
    assign busy       = busy_r;
endmodule

// File: tb/tb_crc_frame_rx_ctrl.sv
// Directed bench for crc_frame_rx_ctrl: a frame-level scoreboard model plus a CRC-16/MODBUS engine model.
// Build with FRAME_TIMEOUT_EN to exercise the timeout abort; otherwise long gaps must be tolerated.
module tb_crc_frame_rx_ctrl;
    localparam int MAX_LEN = 64;
    localparam int TIMEOUT = 100;
`ifdef FRAME_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    typedef struct { int cyc; logic [7:0] d; logic last; } pay_t;
    typedef struct { int cyc; logic ok; logic [1:0] err; logic [15:0] crc; } done_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] crc_in;
    logic        crc_en, crc_clr, pay_valid, pay_last, frame_done, frame_ok, rx_drop, busy;
    logic [7:0]  crc_data, pay_data;
    logic [1:0]  frame_err;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int rst_chk_cyc = -1;
    int end_cyc = -1;

    pay_t  pq[$];
    done_t dq[$];
    int    drq[$];
    int    clq[$];
    logic [7:0] fb[$];
    logic [7:0] fa[$];
    logic [7:0] pin_q[$];
    logic [7:0] empty_q[$];
    logic [15:0] eng_r;

    crc_frame_rx_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .TO_W(16)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .crc_in(crc_in),
        .crc_en(crc_en), .crc_clr(crc_clr), .crc_data(crc_data), .pay_data(pay_data),
        .pay_valid(pay_valid), .pay_last(pay_last), .frame_done(frame_done),
        .frame_ok(frame_ok), .frame_err(frame_err), .rx_drop(rx_drop), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    function automatic logic [15:0] crc16(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) c = crc_upd(c, q[i]);
        return c;
    endfunction

    // Shared CRC engine: updates the cycle after crc_en, clears on crc_clr, resets with rst
    always @(posedge clk) begin
        if (!rst) eng_r <= 16'hFFFF;
        else if (crc_clr) eng_r <= 16'hFFFF;
        else if (crc_en) eng_r <= crc_upd(eng_r, crc_data);
    end
    assign crc_in = eng_r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output int k);
        rx_data  = b;
        rx_valid = 1'b1;
        k        = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic mk_frame(input logic [7:0] p[$], input logic swap);
        logic [15:0] c;
        c  = crc16(p);
        fb = p;
        fb.push_front(8'(p.size()));
        if (swap) begin
            fb.push_back(c[15:8]);
            fb.push_back(c[7:0]);
        end else begin
            fb.push_back(c[7:0]);
            fb.push_back(c[15:8]);
        end
    endtask

    // Sends fb, optionally pausing gap_len cycles after byte gap_at, and records what the frame must produce
    task automatic run_frame(input int gap_at, input int gap_len);
        int k, len;
        logic [7:0] pay[$];
        logic [15:0] rcv;
        pay_t pe_t;
        done_t de_t;
        len = int'(fb[0]);
        if (len > MAX_LEN) begin
            send_byte(fb[0], k);
            de_t = '{k + 1, 1'b0, 2'd2, crc16(pay)};
            dq.push_back(de_t);
        end else begin
            rcv = {fb[len + 2], fb[len + 1]};
            for (int i = 0; i <= len + 2; i++) begin
                send_byte(fb[i], k);
                if (i >= 1 && i <= len) begin
                    pay.push_back(fb[i]);
                    pe_t = '{k + 1, fb[i], (i == len)};
                    pq.push_back(pe_t);
                end
                if (i == len + 2) begin
                    de_t = '{k + 2, (rcv == crc16(pay)), (rcv == crc16(pay)) ? 2'd0 : 2'd1, crc16(pay)};
                    dq.push_back(de_t);
                end else if (i == gap_at) begin
                    if (TO_ON && gap_len >= TIMEOUT) begin
                        de_t = '{k + TIMEOUT + 1, 1'b0, 2'd3, crc16(pay)};
                        dq.push_back(de_t);
                        idle(gap_len);
                        break;
                    end else begin
                        idle(gap_len);
                    end
                end
            end
        end
    endtask

    pay_t  pe_c;
    done_t de_c;
    int    ic;

    // Single compare process: every output event is matched against the scoreboard
    always @(negedge clk) begin
        if (cyc == 3 || cyc == rst_chk_cyc) begin
            chk("reset_outputs", 32'({crc_en, crc_clr, crc_data, pay_data, pay_valid, pay_last,
                                      frame_done, frame_ok, frame_err, rx_drop, busy}), 32'd0);
        end
        if (cyc == 3) begin
            chk("model_crc_pin", 32'(crc16(pin_q)), 32'h0000_0A84);
            chk("model_crc_empty", 32'(crc16(empty_q)), 32'h0000_FFFF);
        end
        if (pay_valid || (pq.size() > 0 && pq[0].cyc == cyc)) begin
            if (pq.size() == 0) begin
                chk("pay_valid_unexpected", 32'(pay_valid), 32'd0);
            end else begin
                pe_c = pq.pop_front();
                chk("pay_valid", 32'(pay_valid), 32'd1);
                chk("pay_cycle", cyc, pe_c.cyc);
                chk("pay_data", 32'(pay_data), 32'(pe_c.d));
                chk("pay_last", 32'(pay_last), 32'(pe_c.last));
                chk("crc_en", 32'(crc_en), 32'd1);
                chk("crc_data", 32'(crc_data), 32'(pe_c.d));
                chk("busy_in_frame", 32'(busy), 32'd1);
            end
        end else if (crc_en || pay_last) begin
            chk("stray_crc_en_or_last", 32'({crc_en, pay_last}), 32'd0);
        end
        if (frame_done || (dq.size() > 0 && dq[0].cyc == cyc)) begin
            if (dq.size() == 0) begin
                chk("frame_done_unexpected", 32'(frame_done), 32'd0);
            end else begin
                de_c = dq.pop_front();
                chk("frame_done", 32'(frame_done), 32'd1);
                chk("done_cycle", cyc, de_c.cyc);
                chk("frame_ok", 32'(frame_ok), 32'(de_c.ok));
                chk("frame_err", 32'(frame_err), 32'(de_c.err));
                chk("crc_in_at_done", 32'(crc_in), 32'(de_c.crc));
                clq.push_back(de_c.cyc + 1);
            end
        end
        if (crc_clr || (clq.size() > 0 && clq[0] == cyc)) begin
            if (clq.size() == 0) begin
                chk("crc_clr_unexpected", 32'(crc_clr), 32'd0);
            end else begin
                ic = clq.pop_front();
                chk("crc_clr", 32'(crc_clr), 32'd1);
                chk("clr_cycle", cyc, ic);
                chk("crc_en_with_clr", 32'(crc_en), 32'd0);
            end
        end
        if (rx_drop || (drq.size() > 0 && drq[0] == cyc)) begin
            if (drq.size() == 0) begin
                chk("rx_drop_unexpected", 32'(rx_drop), 32'd0);
            end else begin
                ic = drq.pop_front();
                chk("rx_drop", 32'(rx_drop), 32'd1);
                chk("drop_cycle", cyc, ic);
            end
        end
        if (cyc == end_cyc) begin
            chk("pay_left", pq.size(), 32'd0);
            chk("done_left", dq.size(), 32'd0);
            chk("clr_left", clq.size(), 32'd0);
            chk("drop_left", drq.size(), 32'd0);
        end
        if (cyc > 50000) begin
            $display("FAIL watchdog: got cycle %0d, limit 50000", cyc);
            $fatal(1);
        end
    end

    initial begin
        int k;
        logic [7:0] pl[$];
        pay_t pe_i;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pin_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        fa    = '{8'h06, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        repeat (4) @(negedge clk);
        rst = 1'b1;
        idle(2);
        // good frame, corrupted CRC, then good again
        fb = fa; run_frame(-1, 0); idle(2);
        fb = fa; fb[8] = 8'h0B; run_frame(-1, 0); idle(2);
        fb = fa; run_frame(-1, 0); idle(2);
        // empty payload, oversize LEN, LEN at the limit, single byte with swapped CRC
        fb = '{8'h00, 8'hFF, 8'hFF}; run_frame(-1, 0); idle(2);
        fb = '{8'h41}; run_frame(-1, 0); idle(2);
        pl.delete();
        for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'(i * 7 + 3));
        mk_frame(pl, 1'b0); run_frame(-1, 0); idle(2);
        pl = '{8'h5A}; mk_frame(pl, 1'b1); run_frame(-1, 0); idle(2);
        // bytes arriving in CHECK and CLEAR are dropped, next frame starts cleanly
        fb = fa; run_frame(-1, 0);
        send_byte(8'h06, k); drq.push_back(k + 1);
        send_byte(8'h02, k); drq.push_back(k + 1);
        fb = fa; run_frame(-1, 0); idle(2);
        // long gap mid-frame, then a gap one short of the timeout
        fb = fa; run_frame(2, TIMEOUT + 5); idle(2);
        fb = fa; run_frame(3, TIMEOUT - 1); idle(2);
        fb = fa; run_frame(-1, 0); idle(2);
        // reset after three payload bytes
        send_byte(8'h06, k);
        for (int i = 1; i <= 3; i++) begin
            send_byte(fa[i], k);
            pe_i = '{k + 1, fa[i], 1'b0};
            pq.push_back(pe_i);
        end
        rst = 1'b0;
        rst_chk_cyc = cyc + 1;
        idle(1);
        rst = 1'b1;
        idle(3);
        fb = fa; run_frame(-1, 0); idle(4);
        end_cyc = cyc + 1;
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
